// File: rtl/txn_issue_arb.sv
// Round-robin arbiter and credit scheduler feeding one registered memory request channel.
// Optional warp lock (requests of one warp issue back to back) enabled by `TXN_ARB_WARP_LOCK_EN.
//
// state | meaning
// ARB   | any requester may be granted, starting at r_rr_ptr
// LOCK  | only r_lock_id may be granted until it sends its last transaction
module txn_issue_arb #(
  parameter int NREQ       = 4,
  parameter int W          = 32,
  parameter int ADDR_W     = 64,
  parameter int LINE_SHIFT = 6,
  parameter int MAX_OUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_flat,
  input  logic [NREQ*W-1:0]        req_mask_flat,
  input  logic [NREQ-1:0]          req_last,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [W-1:0]             mem_req_lane_mask,
  output logic [$clog2(NREQ)-1:0]  mem_req_src,
  input  logic                     mem_rsp_valid,
  output logic                     credit_err,
  output logic [7:0]               out_count
);

  localparam int SRC_W = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << LINE_SHIFT;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
`ifdef TXN_ARB_WARP_LOCK_EN
  logic [SRC_W-1:0]   r_lock_id, w_lock_id_nxt;
  logic               w_sel_last;
`else
  logic               w_unused_last;
`endif

  logic               r_mem_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [W-1:0]       r_mem_mask;
  logic [SRC_W-1:0]   r_mem_src;
  logic [7:0]         r_out_count;
  logic               r_credit_err;

  logic               w_load;
  logic               w_credit_ok;
  logic [NREQ-1:0]    w_elig;
  logic               w_hi_found, w_lo_found, w_found;
  logic [SRC_W-1:0]   w_hi_idx, w_lo_idx, w_gnt_idx, w_ptr_after;
  logic [NREQ-1:0]    w_gnt_oh;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [W-1:0]       w_sel_mask;
  logic               w_accept, w_issue;

  assign w_load      = !r_mem_valid || mem_req_ready;
  // Registered count is used so a response re-enables grants only on the following cycle.
  assign w_credit_ok = r_out_count < 8'(MAX_OUT);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef TXN_ARB_WARP_LOCK_EN
      w_elig[i] = req_valid[i] && w_load && w_credit_ok &&
                  ((r_state == ARB) || (SRC_W'(i) == r_lock_id));
`else
      w_elig[i] = req_valid[i] && w_load && w_credit_ok;
`endif
    end
  end

  // Descending scan so the lowest index in each half (at/after ptr, before ptr) wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SRC_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SRC_W'(i);
        end
      end
    end
    w_found   = w_hi_found || w_lo_found;
    w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_gnt_oh   = '0;
    w_sel_addr = '0;
    w_sel_mask = '0;
`ifdef TXN_ARB_WARP_LOCK_EN
    w_sel_last = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (w_found && (w_gnt_idx == SRC_W'(i))) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_addr  = req_addr_flat[i*ADDR_W +: ADDR_W];
        w_sel_mask  = req_mask_flat[i*W +: W];
`ifdef TXN_ARB_WARP_LOCK_EN
        w_sel_last  = req_last[i];
`endif
      end
    end
  end

`ifndef TXN_ARB_WARP_LOCK_EN
  assign w_unused_last = ^req_last;
`endif

  assign req_ready   = w_gnt_oh;
  assign w_accept    = w_found;
  // Zero-mask transactions are consumed without loading the output or taking a credit.
  assign w_issue     = w_accept && (|w_sel_mask);
  assign w_ptr_after = (w_gnt_idx == SRC_W'(NREQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_rr_ptr  <= '0;
`ifdef TXN_ARB_WARP_LOCK_EN
      r_lock_id <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
`ifdef TXN_ARB_WARP_LOCK_EN
      r_lock_id <= w_lock_id_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
`ifdef TXN_ARB_WARP_LOCK_EN
    w_lock_id_nxt = r_lock_id;
`endif
    case (r_state)
      ARB, LOCK: begin
`ifdef TXN_ARB_WARP_LOCK_EN
        if (w_accept) begin
          if (!w_sel_last) begin
            w_state_nxt   = LOCK;
            w_lock_id_nxt = w_gnt_idx;
          end else begin
            w_state_nxt  = ARB;
            w_rr_ptr_nxt = w_ptr_after;
          end
        end
`else
        w_state_nxt = ARB;
        if (w_accept) w_rr_ptr_nxt = w_ptr_after;
`endif
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_mask  <= '0;
      r_mem_src   <= '0;
    end else if (w_issue) begin
      r_mem_valid <= 1'b1;
      r_mem_addr  <= w_sel_addr & ADDR_MASK;
      r_mem_mask  <= w_sel_mask;
      r_mem_src   <= w_gnt_idx;
    end else if (mem_req_ready) begin
      r_mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_count  <= '0;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_issue, mem_rsp_valid})
        2'b10: r_out_count <= r_out_count + 8'd1;
        2'b01: begin
          if (r_out_count == 8'd0) r_credit_err <= 1'b1;
          else                     r_out_count  <= r_out_count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_valid     = r_mem_valid;
  assign mem_req_addr      = r_mem_addr;
  assign mem_req_lane_mask = r_mem_mask;
  assign mem_req_src       = r_mem_src;
  assign out_count         = r_out_count;
  assign credit_err        = r_credit_err;

endmodule

// File: tb/tb_txn_issue_arb.sv
// Self-checking bench for txn_issue_arb: transaction-level model checked every cycle plus
// directed scenarios with literal expectations. Honours `TXN_ARB_WARP_LOCK_EN like the design.
module tb_txn_issue_arb;
  localparam int NREQ = 4, W = 32, ADDR_W = 64, LINE_SHIFT = 6, MAX_OUT = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr_flat;
  logic [NREQ*W-1:0]      req_mask_flat;
  logic [NREQ-1:0]        req_last;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic [W-1:0]           mem_req_lane_mask;
  logic [1:0]             mem_req_src;
  logic                   mem_rsp_valid;
  logic                   credit_err;
  logic [7:0]             out_count;

  int n_cmp = 0;
  int n_bad = 0;

  txn_issue_arb #(.NREQ(NREQ), .W(W), .ADDR_W(ADDR_W), .LINE_SHIFT(LINE_SHIFT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_flat(req_addr_flat), .req_mask_flat(req_mask_flat), .req_last(req_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_lane_mask(mem_req_lane_mask), .mem_req_src(mem_req_src),
    .mem_rsp_valid(mem_rsp_valid), .credit_err(credit_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending-output slot, an in-flight count and a rotating pointer.
  bit          m_valid, m_err, m_locked;
  logic [63:0] m_addr;
  logic [31:0] m_mask;
  int          m_src, m_ptr, m_cnt, m_lock;

  always @(negedge clk) begin : p_model
    int g;
    bit ld;
    logic [NREQ-1:0] er;
    logic [31:0] mk;
    if (!rst_n) begin
      m_valid = 0; m_err = 0; m_locked = 0; m_addr = '0; m_mask = '0;
      m_src = 0; m_ptr = 0; m_cnt = 0; m_lock = 0;
    end else begin
      ld = !m_valid || mem_req_ready;
      g  = -1;
      if (ld && m_cnt < MAX_OUT) begin
        for (int o = 0; o < NREQ; o++) begin
          int k;
          k = (m_ptr + o) % NREQ;
          if (g < 0 && req_valid[k] && (!m_locked || k == m_lock)) g = k;
        end
      end
      er = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("model_req_ready", 64'(req_ready), 64'(er));
      chk("model_valid", 64'(mem_req_valid), 64'(m_valid));
      chk("model_addr", mem_req_addr, m_addr);
      chk("model_mask", 64'(mem_req_lane_mask), 64'(m_mask));
      chk("model_src", 64'(mem_req_src), 64'(m_src));
      chk("model_count", 64'(out_count), 64'(m_cnt));
      chk("model_err", 64'(credit_err), 64'(m_err));
      mk = (g >= 0) ? req_mask_flat[g*W +: W] : '0;
      if (g >= 0 && mk != 0) begin
        m_valid = 1;
        m_addr  = (req_addr_flat[g*ADDR_W +: ADDR_W] >> LINE_SHIFT) << LINE_SHIFT;
        m_mask  = mk;
        m_src   = g;
        if (!mem_rsp_valid) m_cnt++;
      end else begin
        if (mem_req_ready) m_valid = 0;
        if (mem_rsp_valid) begin
          if (m_cnt == 0) m_err = 1;
          else m_cnt--;
        end
      end
      if (g >= 0) begin
`ifdef TXN_ARB_WARP_LOCK_EN
        if (!req_last[g]) begin
          m_locked = 1; m_lock = g;
        end else begin
          m_locked = 0; m_ptr = (g + 1) % NREQ;
        end
`else
        m_ptr = (g + 1) % NREQ;
`endif
      end
    end
  end

  task automatic set_req(input int i, input bit v, input logic [63:0] a, input logic [31:0] m,
                         input bit last);
    req_valid[i] = v;
    req_addr_flat[i*ADDR_W +: ADDR_W] = a;
    req_mask_flat[i*W +: W] = m;
    req_last[i] = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};
    req_valid = '0; req_addr_flat = '0; req_mask_flat = '0; req_last = '1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;

    do_reset();
    chk("reset_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_addr", mem_req_addr, 64'd0);
    chk("reset_src", 64'(mem_req_src), 64'd0);
    chk("reset_count", 64'(out_count), 64'd0);
    chk("reset_err", 64'(credit_err), 64'd0);

    // Round robin with a response every cycle
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'h1000 + 64'(i * 64), 32'h1 << i, 1'b1);
    mem_rsp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_valid", 64'(mem_req_valid), 64'd1);
      chk("rr_src", 64'(mem_req_src), 64'(rr_exp[c]));
    end
    chk("rr_count", 64'(out_count), 64'd0);
    chk("rr_err", 64'(credit_err), 64'd0);

    // Alignment, then a zero-mask discard
    mem_rsp_valid = 1'b0;
    req_valid = '0;
    set_req(2, 1'b1, 64'h1234_567F, 32'h0000_00FF, 1'b1);
    step();
    chk("align_addr", mem_req_addr, 64'h1234_5640);
    chk("align_src", 64'(mem_req_src), 64'd2);
    chk("align_mask", 64'(mem_req_lane_mask), 64'hFF);
    chk("align_count", 64'(out_count), 64'd1);
    set_req(2, 1'b1, 64'h2000, 32'h0, 1'b1);
    #1 chk("discard_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    chk("discard_valid", 64'(mem_req_valid), 64'd0);
    chk("discard_count", 64'(out_count), 64'd1);
    step();

    // Credit cap
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'h8000 + 64'(i * 64), 32'hF, 1'b1);
    repeat (16) step();
    chk("cap_count16", 64'(out_count), 64'd16);
    chk("cap_ready0", 64'(req_ready), 64'd0);
    repeat (3) step();
    chk("cap_hold_count", 64'(out_count), 64'd16);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    chk("cap_count15", 64'(out_count), 64'd15);
    chk("cap_regrant", 64'(req_ready), 64'b0001);
    step();
    chk("cap_count_back", 64'(out_count), 64'd16);
    chk("cap_ready_again0", 64'(req_ready), 64'd0);
    chk("cap_regrant_src", 64'(mem_req_src), 64'd0);

    // Backpressure
    do_reset();
    mem_req_ready = 1'b0;
    set_req(3, 1'b1, 64'h4000_0010, 32'hF0F0, 1'b1);
    step();
    set_req(3, 1'b1, 64'h5000_0000, 32'h0F0F, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready0", 64'(req_ready), 64'd0);
      chk("bp_addr_hold", mem_req_addr, 64'h4000_0000);
      chk("bp_mask_hold", 64'(mem_req_lane_mask), 64'hF0F0);
      step();
    end
    mem_req_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'b1000);
    step();
    chk("bp_new_addr", mem_req_addr, 64'h5000_0000);
    chk("bp_new_valid", 64'(mem_req_valid), 64'd1);

    // Credit error, then reset in the middle of a stall
    do_reset();
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("err_set", 64'(credit_err), 64'd1);
    chk("err_count0", 64'(out_count), 64'd0);
    repeat (3) step();
    chk("err_sticky", 64'(credit_err), 64'd1);
    mem_req_ready = 1'b0;
    set_req(1, 1'b1, 64'h7777_0000, 32'h1, 1'b1);
    step();
    req_valid = '0;
    chk("stall_loaded", 64'(mem_req_valid), 64'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_addr", mem_req_addr, 64'd0);
    chk("arst_mask", 64'(mem_req_lane_mask), 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_err", 64'(credit_err), 64'd0);

    // Warp lock: requester 1 sends last = 0,0,1 while requester 0 stays valid
    do_reset();
    mem_rsp_valid = 1'b1;
    set_req(0, 1'b1, 64'h100, 32'h1, 1'b1);
    step();
    chk("wl_first_src", 64'(mem_req_src), 64'd0);
    set_req(1, 1'b1, 64'h200, 32'h2, 1'b0);
    step();
    chk("wl_src_a", 64'(mem_req_src), 64'd1);
`ifdef TXN_ARB_WARP_LOCK_EN
    step();
    chk("wl_src_b", 64'(mem_req_src), 64'd1);
    req_valid[1] = 1'b0;
    #1 chk("wl_locked_idle", 64'(req_ready), 64'd0);
    step();
    chk("wl_idle_valid", 64'(mem_req_valid), 64'd0);
    set_req(1, 1'b1, 64'h240, 32'h2, 1'b1);
    step();
    chk("wl_src_c", 64'(mem_req_src), 64'd1);
    req_valid[1] = 1'b0;
    step();
    chk("wl_after_src", 64'(mem_req_src), 64'd0);
`else
    step();
    chk("nolock_rotate_src", 64'(mem_req_src), 64'd0);
    step();
    chk("nolock_rotate_src2", 64'(mem_req_src), 64'd1);
`endif
    mem_rsp_valid = 1'b0;
    req_valid = '0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/txn_issue_arb.md
# txn_issue_arb

Round-robin arbiter and credit scheduler that shares one memory request channel among `NREQ` warp transaction-formation units. Each unit emits line-aligned (address, lane mask) transactions. This block:
- picks one eligible requester per cycle;
- tags the transaction with its source;
- registers it into a single-entry output stage toward the memory controller;
- bounds in-flight transactions with an outstanding-credit counter that is replenished by response pulses.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (≥2).
- `W`, 32: warp width, i.e. lane-mask bits.
- `ADDR_W`, 64: address width.
- `LINE_SHIFT`, 6: log2 of line bytes.
- `MAX_OUT`, 16: maximum in-flight transactions (1..255).

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester transaction valid.
- `req_ready`  out  NREQ  per-requester accept; combinational.
- `req_addr_flat`  in  NREQ*ADDR_W  per-requester address; slice i = requester i.
- `req_mask_flat`  in  NREQ*W  per-requester lane mask.
- `req_last`  in  NREQ  marks the final transaction of a warp.
- `mem_req_valid`  out  1  registered request valid.
- `mem_req_ready`  in  1  memory channel accept.
- `mem_req_addr`  out  ADDR_W  line-aligned address.
- `mem_req_lane_mask`  out  W  lane mask.
- `mem_req_src`  out  $clog2(NREQ)  source requester index.
- `mem_rsp_valid`  in  1  one-cycle pulse; returns one credit.
- `credit_err`  out  1  sticky; set when a response arrives while the count is 0.
- `out_count`  out  8  current outstanding count.

## Operation
- **Output stage.** Single register `{valid, addr, mask, src}`. `load = !mem_req_valid || mem_req_ready`.
- **Eligibility.** Requester i is eligible when all of the following hold:
  - `req_valid[i]` is asserted;
  - `load` is true;
  - `out_count < MAX_OUT`;
  - the lock state allows i (see Configuration).
- **Grant.** The first eligible index at or after `rr_ptr`, scanning with modulo-NREQ wrap. `req_ready[i]` is asserted only for the granted i; all other bits are 0.
- **Accept.** An accept is `req_valid[k] && req_ready[k]`. On accept:
  - `mem_req_addr` takes the requester address with its low `LINE_SHIFT` bits forced to 0;
  - `mem_req_lane_mask` and `mem_req_src = k` are loaded;
  - `mem_req_valid` is set.
- **Zero-mask requests.** If the accepted mask is all-zero, the transaction is accepted and discarded:
  - no output load;
  - no credit consumed;
  - arbitration pointer and lock state still advance as for a normal accept.
- **Output hold.** Output fields remain stable while `mem_req_valid && !mem_req_ready`. `mem_req_valid` clears on a ready cycle with no new accept.
- **Credits.** `out_count` increments on each non-discarded accept (load) and decrements on `mem_rsp_valid`:
  - simultaneous load and response: unchanged;
  - response at count 0: count stays 0 and `credit_err` is set (cleared only by reset).
- **Pointer.** In unlocked mode, `rr_ptr = (k+1) mod NREQ` after an accept from k. The pointer is unchanged on cycles with no accept.
- **FSM states.**
  - `ARB`: any requester is eligible.
  - `LOCK`: only `lock_id` is eligible.
  - The FSM is `ARB`-only when the macro is absent.

## Timing
- **Reset values.** `mem_req_valid`, `mem_req_addr`, `mem_req_lane_mask`, `mem_req_src`, `out_count` and `credit_err` are all 0. `rr_ptr` = 0 and state = `ARB`.
- **Latency.** Accept in cycle N gives `mem_req_valid` in N+1.
- **Throughput.** One transaction per cycle with `mem_req_ready` held high.
- **Backpressure.** `req_ready` depends combinationally on `mem_req_ready`. There is no combinational path from `req_valid` to `mem_req_valid`.
- **Credit full.** `out_count == MAX_OUT` forces `req_ready = 0`. A response in cycle N re-enables grants in N+1, because the check uses the registered count.
- **Reset mid-operation.** A pending output transaction is dropped, credits are cleared, and the lock is released.

## Configuration
- **`TXN_ARB_WARP_LOCK_EN` defined.**
  - An accept from k with `req_last[k] = 0` enters `LOCK` with `lock_id = k`, and `rr_ptr` is not advanced.
  - While in `LOCK`, only k is eligible, even if k deasserts valid.
  - An accept from k with `req_last[k] = 1` returns to `ARB` and sets `rr_ptr = (k+1) mod NREQ`.
  - Effect: all transactions of a warp issue contiguously.
- **`TXN_ARB_WARP_LOCK_EN` undefined.**
  - `req_last` is ignored.
  - The pointer rotates after every accept.

## Test plan
- **Round-robin fairness.** NREQ=4, all `req_valid` = 1111, `mem_req_ready` = 1, `mem_rsp_valid` pulsed every cycle, macro off.
  - Expected: `mem_req_src` sequence 0,1,2,3,0 on consecutive cycles starting 1 cycle after reset release.
- **Alignment and discard.**
  - Requester 2 addr 0x1234_567F, mask 0x0000_00FF → `mem_req_addr` 0x1234_5640, src 2.
  - A mask of 0 → no `mem_req_valid`, `out_count` unchanged.
- **Credit cap.** MAX_OUT=16, no responses.
  - Exactly 16 issues, then `req_ready` = 0.
  - One `mem_rsp_valid` pulse → one further grant in the following cycle; `out_count` returns to 16.
- **Backpressure.** Hold `mem_req_ready` = 0 for 5 cycles with one transaction loaded.
  - Expected: outputs stable, `req_ready` = 0.
  - Release → the next grant is taken in the same cycle ready is seen.
- **Warp lock, macro on.** Requester 1 sends 3 transactions with `req_last` = 0,0,1 while requester 0 is valid throughout.
  - Expected: src 1,1,1, then 2 (if valid) or 0.
- **Credit error and reset.**
  - `mem_rsp_valid` at count 0 → `credit_err` = 1 and sticky.
  - Assert `rst_n` low mid-stall → all outputs 0 asynchronously.
